cuckoo_insert_ctrl: RTL and testbench

- Clocked controller that owns two DEPTH-entry cuckoo hash tables.
- Sequences insert operations, including the bounded eviction ("kick") chain between the two tables, and single-probe lookups.
- Requesters use a valid/ready handshake; one response pulse is returned per operation.
- Sits between key producers and the hashing storage; replaces free-running combinational insert loops with a deterministic FSM.

---
 rtl/cuckoo_pkg.sv | 21 ++
 rtl/cuckoo_insert_ctrl_if.sv | 29 ++
 rtl/cuckoo_index.sv | 29 ++
 rtl/cuckoo_insert_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cuckoo_insert_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cuckoo_pkg.sv
// Shared types for the cuckoo hash insert/lookup controller.
// Status codes, op codes and the controller state encoding.
package cuckoo_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_DUP  = 2'd2,
        ST_FAIL = 2'd3
    } status_e;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_LOOKUP = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLACE  = 2'd1,
        LOOKUP = 2'd2
    } state_e;

endpackage

// File: rtl/cuckoo_insert_ctrl_if.sv
// Request/response bundle between key producers and the cuckoo controller.
// The requester drives the master side; the controller is the slave.
interface cuckoo_insert_ctrl_if #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [KEY_W-1:0] in_key;
    logic             resp_valid;
    logic [1:0]       resp_status;
    logic [KEY_W-1:0] resp_key;
    logic             resp_side;
    logic [IDX_W-1:0] resp_idx;
    logic [3:0]       resp_kicks;

    modport master (
        output in_valid, in_op, in_key,
        input  in_ready, resp_valid, resp_status, resp_key,
        input  resp_side, resp_idx, resp_kicks
    );

    modport slave (
        input  in_valid, in_op, in_key,
        output in_ready, resp_valid, resp_status, resp_key,
        output resp_side, resp_idx, resp_kicks
    );
endinterface

// File: rtl/cuckoo_index.sv
// Combinational slot indices for both cuckoo tables.
// i1 = cube of (key mod DEPTH); i2 = (2^key + key) mod DEPTH, wrapping.
module cuckoo_index #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 20,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [KEY_W-1:0] key_i,
    output logic [IDX_W-1:0] i1_o,
    output logic [IDX_W-1:0] i2_o
);
    localparam logic [KEY_W-1:0] DK  = KEY_W'(DEPTH);
    localparam logic [31:0]      D32 = 32'(DEPTH);

    logic [31:0]      m;
    logic [31:0]      cube;
    logic [KEY_W-1:0] pw;
    logic [KEY_W-1:0] sum;

    always_comb begin
        m    = 32'(key_i % DK);
        cube = m * m * m;
        // 2^n vanishes modulo the word size once n reaches 32
        pw   = (key_i < KEY_W'(32)) ? (KEY_W'(1) << key_i[4:0]) : '0;
        sum  = pw + key_i;
        i1_o = IDX_W'(cube % D32);
        i2_o = IDX_W'(sum % DK);
    end
endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Two-table cuckoo hash controller: inserts with bounded eviction chain,
// single-probe lookups, one response pulse per accepted request.
module cuckoo_insert_ctrl
    import cuckoo_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int DEPTH     = 20,
    parameter int MAX_KICKS = 8,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    cuckoo_insert_ctrl_if.slave  bus,
    input  logic                 rd_side,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [KEY_W-1:0]     rd_data,
    output logic                 rd_filled
);
    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             side_q, side_d;
    logic [3:0]       kicks_q, kicks_d;
    logic [IDX_W-1:0] home_q, home_d;
    logic [DEPTH-1:0] f0_q, f0_d, f1_q, f1_d;
    logic [KEY_W-1:0] t0_q [DEPTH];
    logic [KEY_W-1:0] t1_q [DEPTH];

    logic             rv_q, rv_d;
    status_e          rst_q, rst_d;
    logic [KEY_W-1:0] rkey_q, rkey_d;
    logic             rside_q, rside_d;
    logic [IDX_W-1:0] ridx_q, ridx_d;
    logic [3:0]       rkick_q, rkick_d;

    logic             wr_en, wr_side;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] i1, i2, tgt_idx;
    logic             hit0, hit1, tgt_full;
    logic [KEY_W-1:0] tgt_key;

    cuckoo_index #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_idx (
        .key_i (key_q),
        .i1_o  (i1),
        .i2_o  (i2)
    );

    assign hit0     = f0_q[i1] && (t0_q[i1] == key_q);
    assign hit1     = f1_q[i2] && (t1_q[i2] == key_q);
    assign tgt_idx  = side_q ? i2 : i1;
    assign tgt_full = side_q ? f1_q[i2] : f0_q[i1];
    assign tgt_key  = side_q ? t1_q[i2] : t0_q[i1];

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        side_d  = side_q;
        kicks_d = kicks_q;
        home_d  = home_q;
        f0_d    = f0_q;
        f1_d    = f1_q;
        wr_en   = 1'b0;
        wr_side = side_q;
        wr_idx  = tgt_idx;
        rv_d    = 1'b0;
        rst_d   = rst_q;
        rkey_d  = rkey_q;
        rside_d = rside_q;
        ridx_d  = ridx_q;
        rkick_d = rkick_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    f0_d = '0;
                    f1_d = '0;
                end else if (bus.in_valid) begin
                    key_d   = bus.in_key;
                    side_d  = 1'b0;
                    kicks_d = '0;
                    state_d = (bus.in_op == OP_LOOKUP) ? LOOKUP : PLACE;
                end
            end
            LOOKUP: begin
                state_d = IDLE;
                rv_d    = 1'b1;
                rkey_d  = key_q;
                rkick_d = '0;
                rst_d   = (hit0 || hit1) ? ST_OK : ST_MISS;
                rside_d = !hit0 && hit1;
                ridx_d  = hit0 ? i1 : (hit1 ? i2 : '0);
            end
            PLACE: begin
                if (kicks_q == '0 && (hit0 || hit1)) begin
                    state_d = IDLE;
                    rv_d    = 1'b1;
                    rst_d   = ST_DUP;
                    rkey_d  = key_q;
                    rside_d = !hit0;
                    ridx_d  = hit0 ? i1 : i2;
                    rkick_d = '0;
                end else if (!tgt_full || kicks_q < 4'(MAX_KICKS)) begin
                    wr_en = 1'b1;
                    if (kicks_q == '0)
                        home_d = i1;
                    if (!tgt_full) begin
                        if (side_q) f1_d[tgt_idx] = 1'b1;
                        else        f0_d[tgt_idx] = 1'b1;
                        // Location reported is where the requested key landed
                        state_d = IDLE;
                        rv_d    = 1'b1;
                        rst_d   = ST_OK;
                        rkey_d  = (kicks_q == '0) ? key_q : rkey_q;
                        rside_d = 1'b0;
                        ridx_d  = (kicks_q == '0) ? i1 : home_q;
                        rkick_d = kicks_q;
                    end else begin
                        key_d   = tgt_key;
                        side_d  = !side_q;
                        kicks_d = kicks_q + 4'd1;
                        if (kicks_q == '0)
                            rkey_d = key_q;
                    end
                end else begin
                    state_d = IDLE;
                    rv_d    = 1'b1;
                    rst_d   = ST_FAIL;
                    rkey_d  = key_q;
                    rside_d = side_q;
                    ridx_d  = tgt_idx;
                    rkick_d = kicks_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            side_q  <= 1'b0;
            kicks_q <= '0;
            home_q  <= '0;
            f0_q    <= '0;
            f1_q    <= '0;
            rv_q    <= 1'b0;
            rst_q   <= ST_OK;
            rkey_q  <= '0;
            rside_q <= 1'b0;
            ridx_q  <= '0;
            rkick_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            side_q  <= side_d;
            kicks_q <= kicks_d;
            home_q  <= home_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            rv_q    <= rv_d;
            rst_q   <= rst_d;
            rkey_q  <= rkey_d;
            rside_q <= rside_d;
            ridx_q  <= ridx_d;
            rkick_q <= rkick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_side) t1_q[wr_idx] <= key_q;
            else         t0_q[wr_idx] <= key_q;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.resp_valid  = rv_q;
    assign bus.resp_status = rst_q;
    assign bus.resp_key    = rkey_q;
    assign bus.resp_side   = rside_q;
    assign bus.resp_idx    = ridx_q;
    assign bus.resp_kicks  = rkick_q;

    assign rd_data   = rd_side ? t1_q[rd_idx] : t0_q[rd_idx];
    assign rd_filled = rd_side ? f1_q[rd_idx] : f0_q[rd_idx];
endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Directed vector bench for cuckoo_insert_ctrl: table of insert/lookup
// requests with hand-computed responses, plus reset and clear sequences.
module tb_cuckoo_insert_ctrl;
    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       rd_side;
    logic [4:0] rd_idx;
    logic [31:0] rd_data;
    logic       rd_filled;

    int nvec;
    int nmis;

    cuckoo_insert_ctrl_if #(.KEY_W(32), .IDX_W(5)) bus ();

    cuckoo_insert_ctrl #(.KEY_W(32), .DEPTH(20), .MAX_KICKS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus),
        .rd_side   (rd_side),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_filled (rd_filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        op;
        logic [31:0] key;
        logic [1:0]  st;
        logic [1:0]  mask;
        logic [31:0] rkey;
        logic        side;
        logic [4:0]  idx;
        logic [3:0]  kicks;
        int          lat;
        logic        chk_rd;
        logic        rs;
        logic [4:0]  ri;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic s,
                          input logic [4:0] i, input logic [31:0] d);
        rd_side = s;
        rd_idx  = i;
        #1;
        chk({name, "_filled"}, 64'(rd_filled), 64'd1);
        chk({name, "_data"}, 64'(rd_data), 64'(d));
    endtask

    // Called at posedge+1; returns at posedge+1 of the response cycle
    task automatic do_op(input logic op, input logic [31:0] key,
                         input logic hold_clr,
                         output logic got, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_key   = key;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr = hold_clr;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        logic got;
        int   lat;
        int   nfill;
        int   nresp;
        nvec = 0;
        nmis = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        rd_side = 1'b0;
        rd_idx = '0;
        bus.in_valid = 1'b0;
        bus.in_op = 1'b0;
        bus.in_key = '0;

        vecs[0] = '{1'b1, 1'b0, 32'd14, 2'd0, 2'b11, 32'd14, 1'b0, 5'd4,
                    4'd0, 1, 1'b1, 1'b0, 5'd4, 32'd14};
        vecs[1] = '{1'b0, 1'b0, 32'd34, 2'd0, 2'b11, 32'd34, 1'b0, 5'd4,
                    4'd1, 2, 1'b1, 1'b1, 5'd18, 32'd14};
        vecs[2] = '{1'b0, 1'b1, 32'd14, 2'd0, 2'b11, 32'd14, 1'b1, 5'd18,
                    4'd0, 1, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[3] = '{1'b0, 1'b1, 32'd54, 2'd1, 2'b00, 32'd0, 1'b0, 5'd0,
                    4'd0, 1, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[4] = '{1'b0, 1'b0, 32'd14, 2'd2, 2'b11, 32'd14, 1'b1, 5'd18,
                    4'd0, 1, 1'b1, 1'b0, 5'd4, 32'd34};
        vecs[5] = '{1'b1, 1'b0, 32'd34, 2'd0, 2'b11, 32'd34, 1'b0, 5'd4,
                    4'd0, 1, 1'b1, 1'b0, 5'd4, 32'd34};
        vecs[6] = '{1'b0, 1'b0, 32'd54, 2'd0, 2'b11, 32'd54, 1'b0, 5'd4,
                    4'd1, 2, 1'b1, 1'b1, 5'd14, 32'd34};
        vecs[7] = '{1'b0, 1'b0, 32'd74, 2'd3, 2'b10, 32'd34, 1'b0, 5'd0,
                    4'd8, 9, 1'b1, 1'b0, 5'd4, 32'd74};

        do_reset();
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp", {bus.resp_status, bus.resp_key, bus.resp_side,
                         bus.resp_idx, bus.resp_kicks}, 64'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_before) do_reset();
            do_op(vecs[v].op, vecs[v].key, 1'b0, got, lat);
            chk($sformatf("v%0d_valid", v), 64'(got), 64'd1);
            chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
            chk($sformatf("v%0d_ready", v), 64'(bus.in_ready), 64'd1);
            chk($sformatf("v%0d_status", v), 64'(bus.resp_status),
                64'(vecs[v].st));
            chk($sformatf("v%0d_kicks", v), 64'(bus.resp_kicks),
                64'(vecs[v].kicks));
            if (vecs[v].mask[1])
                chk($sformatf("v%0d_key", v), 64'(bus.resp_key),
                    64'(vecs[v].rkey));
            if (vecs[v].mask[0])
                chk($sformatf("v%0d_loc", v), {bus.resp_side, bus.resp_idx},
                    {vecs[v].side, vecs[v].idx});
            if (vecs[v].chk_rd)
                rd_chk($sformatf("v%0d_rd", v), vecs[v].rs, vecs[v].ri,
                       vecs[v].rdat);
            @(posedge clk);
            #1;
        end
        rd_chk("fail_t2", 1'b1, 5'd14, 32'd54);

        // Reset dropped in the middle of the 74 eviction chain
        do_reset();
        do_op(1'b0, 32'd34, 1'b0, got, lat);
        do_op(1'b0, 32'd54, 1'b0, got, lat);
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_key   = 32'd74;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.resp_valid), 64'd0);
        nfill = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 20; i++) begin
                rd_side = s[0];
                rd_idx  = i[4:0];
                #0.1;
                if (rd_filled) nfill++;
            end
        chk("midrst_filled", 64'(nfill), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 64'(bus.in_ready), 64'd1);
        nresp = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) nresp++;
        end
        chk("midrst_noresp", 64'(nresp), 64'd0);

        // clr together with in_valid in IDLE wins; request is dropped
        do_op(1'b0, 32'd14, 1'b0, got, lat);
        @(posedge clk);
        #1;
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 1'b0;
        bus.in_key = 32'd54;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        rd_side = 1'b0;
        rd_idx = 5'd4;
        #1;
        chk("clr_filled", 64'(rd_filled), 64'd0);
        chk("clr_ready", 64'(bus.in_ready), 64'd1);
        nresp = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid || !bus.in_ready) nresp++;
        end
        chk("clr_noaccept", 64'(nresp), 64'd0);

        // clr held while the insert is in PLACE has no effect
        do_op(1'b0, 32'd14, 1'b0, got, lat);
        chk("clrp_pre", 64'(bus.resp_status), 64'd0);
        @(posedge clk);
        #1;
        do_op(1'b0, 32'd34, 1'b1, got, lat);
        chk("clrp_valid", 64'(got), 64'd1);
        chk("clrp_lat", 64'(lat), 64'd2);
        chk("clrp_resp", {bus.resp_status, bus.resp_kicks},
            {2'd0, 4'd1});
        rd_chk("clrp_t1", 1'b0, 5'd4, 32'd34);
        rd_chk("clrp_t2", 1'b1, 5'd18, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
